// File: rtl/inta_sequencer_if.sv
// CPU/control-facing signal bundle of the PIC acknowledge sequencer.
// The slave modport is the sequencer's view; the master drives requests and INTA.
interface inta_sequencer_if;
  logic [7:0] irr;
  logic       inta_n;
  logic [4:0] vector_base;
  logic       eoi_valid;
  logic       eoi_specific;
  logic [2:0] eoi_level;
  logic       int_out;
  logic       freeze;
  logic [7:0] clear_interrupt_request;
  logic [7:0] isr;
  logic [7:0] data_out;
  logic       data_oe;

  modport slave (
    input  irr, inta_n, vector_base, eoi_valid, eoi_specific, eoi_level,
    output int_out, freeze, clear_interrupt_request, isr, data_out, data_oe
  );

  modport master (
    output irr, inta_n, vector_base, eoi_valid, eoi_specific, eoi_level,
    input  int_out, freeze, clear_interrupt_request, isr, data_out, data_oe
  );
endinterface

// File: rtl/inta_sequencer.sv
// 8086-mode INTA responder of an 8259-style PIC: raises INT, runs the two-pulse
// acknowledge, owns the in-service register and applies EOI commands.
module inta_sequencer #(
  parameter bit          AEOI        = 1'b0,
  parameter int unsigned SPURIOUS_ID = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  inta_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACK1, WAIT2, ACK2} state_t;

  state_t     state_q, state_d;
  logic       inta_q;
  logic       int_out_q, int_out_d;
  logic [7:0] clr_q, clr_d;
  logic [7:0] isr_q, isr_d;
  logic [7:0] data_out_q, data_out_d;
  logic [2:0] id_q, id_d;
  logic       spur_q, spur_d;

  logic [2:0] win, cur;
  logic       eligible, fall, rise, ack_start;

  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    lowest_set = 3'd0;
    for (int unsigned i = 8; i > 0; i--) begin
      if (v[i-1]) lowest_set = 3'(i - 1);
    end
  endfunction

  assign win       = lowest_set(bus.irr);
  assign cur       = lowest_set(isr_q);
  assign eligible  = (bus.irr != '0) && ((isr_q == '0) || (win < cur));
  assign fall      = inta_q & ~bus.inta_n;
  assign rise      = ~inta_q & bus.inta_n;
  assign ack_start = (state_q == IDLE) && fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (fall) state_d = ACK1;
      ACK1:  if (rise) state_d = WAIT2;
      WAIT2: if (fall) state_d = ACK2;
      ACK2:  if (rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // freeze and data_oe track the state register directly, so reset drops them at once.
  always_comb begin
    bus.freeze                  = (state_q != IDLE);
    bus.data_oe                 = (state_q == ACK2);
    bus.int_out                 = int_out_q;
    bus.clear_interrupt_request = clr_q;
    bus.isr                     = isr_q;
    bus.data_out                = data_out_q;
  end

  always_comb begin
    int_out_d  = (state_q == IDLE && !fall) ? eligible : 1'b0;
    id_d       = id_q;
    spur_d     = spur_q;
    clr_d      = '0;
    data_out_d = data_out_q;
    isr_d      = isr_q;

    if (ack_start) begin
      id_d   = eligible ? win : 3'(SPURIOUS_ID);
      spur_d = !eligible;
    end
    if (state_q == WAIT2 && fall) begin
      data_out_d = {bus.vector_base, id_q};
    end

    // Clears are applied before the set so a same-bit set wins over an EOI.
    if (bus.eoi_valid) begin
      if (bus.eoi_specific) begin
        isr_d[bus.eoi_level] = 1'b0;
      end else if (isr_q != '0) begin
        isr_d[cur] = 1'b0;
      end
    end
    if (AEOI && state_q == ACK2 && rise && !spur_q) begin
      isr_d[id_q] = 1'b0;
    end
    if (ack_start && eligible) begin
      isr_d[win] = 1'b1;
      clr_d[win] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inta_q     <= 1'b1;
      int_out_q  <= 1'b0;
      clr_q      <= '0;
      isr_q      <= '0;
      data_out_q <= '0;
      id_q       <= '0;
      spur_q     <= 1'b0;
    end else begin
      inta_q     <= bus.inta_n;
      int_out_q  <= int_out_d;
      clr_q      <= clr_d;
      isr_q      <= isr_d;
      data_out_q <= data_out_d;
      id_q       <= id_d;
      spur_q     <= spur_d;
    end
  end

endmodule

// File: tb/tb_inta_sequencer.sv
// Directed bench for inta_sequencer: one normal-EOI instance and one AEOI instance.
module tb_inta_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  inta_sequencer_if bus ();
  inta_sequencer_if bus_a ();

  inta_sequencer #(.AEOI(1'b0), .SPURIOUS_ID(7)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  inta_sequencer #(.AEOI(1'b1), .SPURIOUS_ID(7)) u_dut_aeoi (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full two-pulse acknowledge on the normal instance, capturing the clear pulse and vector.
  task automatic ack_seq(output logic [7:0] clr_seen, output logic [7:0] vec_seen,
                         output logic oe_seen);
    bus.inta_n = 1'b0;
    tick();
    clr_seen = bus.clear_interrupt_request;
    tick();
    bus.inta_n = 1'b1;
    tick();
    tick();
    bus.inta_n = 1'b0;
    tick();
    vec_seen = bus.data_out;
    oe_seen  = bus.data_oe;
    bus.inta_n = 1'b1;
    tick();
  endtask

  logic [7:0] clr_s, vec_s;
  logic       oe_s;

  initial begin
    rst_n = 1'b0;
    bus.irr = '0;   bus.inta_n = 1'b1;   bus.vector_base = 5'b01000;
    bus.eoi_valid = 1'b0; bus.eoi_specific = 1'b0; bus.eoi_level = '0;
    bus_a.irr = '0; bus_a.inta_n = 1'b1; bus_a.vector_base = 5'b01000;
    bus_a.eoi_valid = 1'b0; bus_a.eoi_specific = 1'b0; bus_a.eoi_level = '0;
    tick();
    tick();
    chk("rst_int",   bus.int_out, 0);
    chk("rst_frz",   bus.freeze, 0);
    chk("rst_clr",   bus.clear_interrupt_request, 0);
    chk("rst_isr",   bus.isr, 0);
    chk("rst_dout",  bus.data_out, 0);
    chk("rst_oe",    bus.data_oe, 0);
    rst_n = 1'b1;
    tick();

    // 1: basic acknowledge, win = level 2
    bus.irr = 8'h24;
    chk("t1_int_delay", bus.int_out, 0);
    tick();
    chk("t1_int", bus.int_out, 1);
    bus.inta_n = 1'b0;
    tick();
    chk("t1_frz1", bus.freeze, 1);
    chk("t1_int_drop", bus.int_out, 0);
    chk("t1_clr", bus.clear_interrupt_request, 8'h04);
    chk("t1_isr", bus.isr, 8'h04);
    chk("t1_oe_ack1", bus.data_oe, 0);
    tick();
    chk("t1_clr_1cyc", bus.clear_interrupt_request, 0);
    bus.irr = 8'h20;
    bus.inta_n = 1'b1;
    tick();
    chk("t1_frz_wait", bus.freeze, 1);
    chk("t1_oe_wait", bus.data_oe, 0);
    tick();
    bus.inta_n = 1'b0;
    tick();
    chk("t1_oe_ack2", bus.data_oe, 1);
    chk("t1_vec", bus.data_out, 8'h42);
    tick();
    bus.inta_n = 1'b1;
    tick();
    chk("t1_oe_end", bus.data_oe, 0);
    chk("t1_frz_end", bus.freeze, 0);
    chk("t1_isr_keep", bus.isr, 8'h04);

    // 2: lower-priority request blocked, higher one nests
    tick();
    chk("t2_int_blk5", bus.int_out, 0);
    bus.irr = 8'h30;
    tick();
    tick();
    chk("t2_int_blk4", bus.int_out, 0);
    bus.irr = 8'h32;
    tick();
    chk("t2_int_nest", bus.int_out, 1);
    ack_seq(clr_s, vec_s, oe_s);
    bus.irr = 8'h30;
    chk("t2_clr", clr_s, 8'h02);
    chk("t2_vec", vec_s, 8'h41);
    chk("t2_oe", oe_s, 1);
    chk("t2_isr", bus.isr, 8'h06);

    // 3: non-specific then specific EOI
    bus.eoi_valid = 1'b1; bus.eoi_specific = 1'b0;
    tick();
    bus.eoi_valid = 1'b0;
    chk("t3_nseoi", bus.isr, 8'h04);
    bus.eoi_valid = 1'b1; bus.eoi_specific = 1'b1; bus.eoi_level = 3'd2;
    tick();
    bus.eoi_valid = 1'b0;
    chk("t3_seoi", bus.isr, 8'h00);
    tick();
    chk("t3_reeval", bus.int_out, 1);
    bus.irr = 8'h00;
    tick();
    tick();
    chk("t3_int_off", bus.int_out, 0);

    // 4: automatic EOI instance
    bus_a.irr = 8'h80;
    tick();
    chk("t4_int", bus_a.int_out, 1);
    bus_a.inta_n = 1'b0;
    tick();
    chk("t4_clr", bus_a.clear_interrupt_request, 8'h80);
    chk("t4_isr_set", bus_a.isr, 8'h80);
    bus_a.irr = 8'h00;
    bus_a.inta_n = 1'b1;
    tick();
    tick();
    bus_a.inta_n = 1'b0;
    tick();
    chk("t4_vec", bus_a.data_out, 8'h47);
    chk("t4_isr_ack2", bus_a.isr, 8'h80);
    bus_a.inta_n = 1'b1;
    tick();
    chk("t4_isr_aeoi", bus_a.isr, 8'h00);
    chk("t4_oe_end", bus_a.data_oe, 0);

    // 5: request vanishes before the first INTA -> spurious
    bus.vector_base = 5'b10101;
    bus.irr = 8'h08;
    tick();
    chk("t5_int", bus.int_out, 1);
    bus.irr = 8'h00;
    ack_seq(clr_s, vec_s, oe_s);
    chk("t5_clr", clr_s, 8'h00);
    chk("t5_vec", vec_s, 8'hAF);
    chk("t5_oe", oe_s, 1);
    chk("t5_isr", bus.isr, 8'h00);

    // 6: reset in WAIT2, then a fresh acknowledge with a same-bit EOI at the set
    bus.irr = 8'h01;
    tick();
    chk("t6_int", bus.int_out, 1);
    bus.inta_n = 1'b0;
    tick();
    tick();
    bus.inta_n = 1'b1;
    tick();
    tick();
    chk("t6_frz_wait", bus.freeze, 1);
    chk("t6_isr_wait", bus.isr, 8'h01);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_isr", bus.isr, 0);
    chk("t6_rst_oe", bus.data_oe, 0);
    chk("t6_rst_frz", bus.freeze, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t6_int_again", bus.int_out, 1);
    bus.eoi_valid = 1'b1; bus.eoi_specific = 1'b1; bus.eoi_level = 3'd0;
    bus.inta_n = 1'b0;
    tick();
    bus.eoi_valid = 1'b0;
    chk("t6_set_wins", bus.isr, 8'h01);
    chk("t6_clr", bus.clear_interrupt_request, 8'h01);
    tick();
    bus.irr = 8'h00;
    bus.inta_n = 1'b1;
    tick();
    tick();
    bus.inta_n = 1'b0;
    tick();
    chk("t6_oe", bus.data_oe, 1);
    chk("t6_vec", bus.data_out, 8'hA8);
    bus.inta_n = 1'b1;
    tick();
    chk("t6_oe_end", bus.data_oe, 0);
    chk("t6_isr_end", bus.isr, 8'h01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/inta_sequencer.md
Name: inta_sequencer

Overview:
- CPU-facing responder of the 8259-compatible PIC, in 8086 mode.
- Takes the masked pending-request vector from the IRR and raises INT to the CPU.
- Runs the two-pulse INTA acknowledge sequence: freezes the IRR, moves the winning request into the in-service register (ISR), clears it in the IRR, and drives the interrupt vector on the data bus.
- Owns the ISR and handles EOI commands from the control logic.

Parameters:
- AEOI, 0, 1 = automatic EOI: the ISR bit is cleared at the end of the second INTA pulse.
- SPURIOUS_ID, 7, IR level whose vector is returned when INTA arrives with no eligible request.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- irr  input  8  masked pending requests from the IRR; bit 0 is highest priority.
- inta_n  input  1  CPU acknowledge strobe, active low; already synchronous to clk, sampled each cycle.
- vector_base  input  5  ICW2 T7..T3; forms vector bits [7:3].
- eoi_valid  input  1  one-cycle EOI command strobe.
- eoi_specific  input  1  1 = specific EOI, 0 = non-specific EOI.
- eoi_level  input  3  target level for a specific EOI.
- int_out  output  1  interrupt request to the CPU.
- freeze  output  1  holds IRR contents stable during acknowledge.
- clear_interrupt_request  output  8  one-hot, one-cycle pulse that clears the acknowledged IRR bit.
- isr  output  8  in-service register.
- data_out  output  8  vector byte.
- data_oe  output  1  data bus drive enable.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; int_out=0; freeze=0; clear_interrupt_request=0; isr=0; data_out=0; data_oe=0.
- Priority (combinational): win = lowest-index set bit of irr. cur = lowest-index set bit of isr. eligible = irr!=0 and (isr==0 or win<cur).
- Edge detection: inta_n is registered as inta_q. fall = inta_q & ~inta_n; rise = ~inta_q & inta_n.
- FSM states: IDLE, ACK1, WAIT2, ACK2.
- IDLE:
  - int_out is registered; it takes the value of eligible one cycle later.
  - On fall: go to ACK1, freeze=1, int_out=0.
  - Latch id=win if eligible, else SPURIOUS_ID with a spurious flag set.
  - In the same edge, if not spurious: isr[id] is set and clear_interrupt_request[id] pulses for exactly 1 cycle.
- ACK1: data_oe=0. On rise go to WAIT2.
- WAIT2: on fall go to ACK2; next cycle data_out={vector_base,id} and data_oe=1.
- ACK2: data_oe held at 1. On rise:
  - data_oe=0, freeze=0, go to IDLE.
  - If AEOI=1 and not spurious: isr[id] clears in that cycle.
- Spurious acknowledge: isr is unchanged and no clear pulse is issued, but the vector is still driven.
- EOI (any state):
  - Non-specific EOI clears isr[cur]; no effect if isr==0.
  - Specific EOI clears isr[eoi_level].
- EOI coinciding with an ISR set on the same bit: the set wins. Different bits: both apply in the same cycle.
- int_out stays 0 from the first fall until the return to IDLE. After that it re-evaluates with a 1-cycle delay.
- irr changes during ACK1..ACK2 do not alter the latched id.
- A fall while in ACK1 or ACK2 is impossible without an intervening rise; no special handling.
- No timeout: the FSM waits indefinitely for the second INTA pulse.
- Reset asserted mid-sequence returns to IDLE with isr cleared and data_oe=0 immediately, asynchronously.

Test Plan:
1. irr=8'b0010_0100, isr=0, vector_base=5'b01000 -> int_out=1. Two INTA pulses -> clear_interrupt_request=8'h04 for 1 cycle; isr=8'h04; data_out=8'h42 with data_oe=1 only during the second pulse; freeze high from the first fall to the second rise.
2. isr=8'h04, then irr=8'h10 -> int_out stays 0. Then irr=8'h02 -> int_out=1 next cycle. Acknowledge -> isr=8'h06.
3. isr=8'h06, non-specific EOI -> isr=8'h04. Specific EOI with level 2 -> isr=0.
4. AEOI=1, irr=8'h80 -> after the full sequence isr=0, clear pulse 8'h80, vector {base,3'd7}.
5. irr drops to 0 between the int_out rise and the first INTA fall -> spurious: vector {base,3'd7}, isr unchanged, no clear pulse.
6. rst_n pulled low during WAIT2 -> immediately isr=0, data_oe=0, freeze=0. After release, a fresh acknowledge completes normally.
